// File: rtl/next_adr_rom_pkg.sv
// Shared microcode-sequencer constants and the shipped power-on successor image.
package next_adr_rom_pkg;

    localparam int ADR_ROM_ADR_SIZE = 9;
    localparam int OPCODE_RANGE     = 256;
    localparam int IADD_OPCODE      = 'h60;

    // iadd enters the continuation area at OPCODE_RANGE, takes one more step, then ends.
    function automatic int default_next_adr(input int idx);
        if (idx == IADD_OPCODE)      return OPCODE_RANGE;
        if (idx == OPCODE_RANGE)     return OPCODE_RANGE + 1;
        return 0;
    endfunction

endpackage

// File: rtl/next_adr_rom_if.sv
// Bundles the successor-table read and write signals between sequencer and table.
interface next_adr_rom_if
    import next_adr_rom_pkg::*;
#(
    parameter int ADR_W = ADR_ROM_ADR_SIZE
) ();

    logic [ADR_W-1:0] data_in;
    logic [ADR_W-1:0] data_out;
    logic             wr_en;
    logic [ADR_W-1:0] wr_adr;
    logic [ADR_W-1:0] wr_data;

    modport master (
        output data_in,
        output wr_en,
        output wr_adr,
        output wr_data,
        input  data_out
    );

    modport slave (
        input  data_in,
        input  wr_en,
        input  wr_adr,
        input  wr_data,
        output data_out
    );

endinterface

// File: rtl/next_adr_rom.sv
// Writable next-microcode-address table: zero-latency combinational read,
// per-entry registers with asynchronous load of the default image.
module next_adr_rom
    import next_adr_rom_pkg::*;
#(
    parameter int ADR_W = ADR_ROM_ADR_SIZE,
    parameter int DEPTH = 2**ADR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADR_W-1:0] data_in,
    output logic [ADR_W-1:0] data_out,
    input  logic             wr_en,
    input  logic [ADR_W-1:0] wr_adr,
    input  logic [ADR_W-1:0] wr_data
);

    logic [ADR_W-1:0] w_table [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (gi == 0) begin : g_nop
                // Entry 0 is the nop terminator; it has no storage and can never change.
                assign w_table[gi] = '0;
            end else begin : g_reg
                logic [ADR_W-1:0] r_entry;
                logic             w_hit;

                assign w_hit = wr_en && (wr_adr == ADR_W'(gi));

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        r_entry <= ADR_W'(default_next_adr(gi));
                    end else if (w_hit) begin
                        r_entry <= wr_data;
                    end
                end

                assign w_table[gi] = r_entry;
            end
        end

        if (DEPTH == 2**ADR_W) begin : g_full_read
            assign data_out = w_table[data_in];
        end else begin : g_partial_read
            // Addresses beyond the populated range read as end-of-sequence.
            assign data_out = (int'(data_in) < DEPTH) ? w_table[data_in] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_next_adr_rom.sv
// Scoreboard bench for next_adr_rom: expected successors queued at drive time,
// popped and compared once the combinational output has settled.
module tb_next_adr_rom;

    localparam int AW = 9;
    localparam int ND = 512;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    next_adr_rom_if #(.ADR_W(AW)) bus ();

    next_adr_rom #(
        .ADR_W (AW),
        .DEPTH (ND)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (bus.data_in),
        .data_out (bus.data_out),
        .wr_en    (bus.wr_en),
        .wr_adr   (bus.wr_adr),
        .wr_data  (bus.wr_data)
    );

    logic [AW-1:0] model [ND];
    logic [AW-1:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed %03h expected %03h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ND; i++) model[i] = '0;
        model[9'h060] = 9'h100;
        model[9'h100] = 9'h101;
    endtask

    // Push the expectation on drive, pop it once the read mux has settled.
    task automatic rd(input string tag, input logic [AW-1:0] adr);
        bus.data_in = adr;
        exp_q.push_back(model[adr]);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: observed empty-queue expected entry", tag);
        end else begin
            check_val(tag, bus.data_out, exp_q.pop_front());
        end
    endtask

    // One write edge; rd_adr is read just before and just after the edge.
    task automatic wr_edge(input string tag, input logic [AW-1:0] adr,
                           input logic [AW-1:0] dat, input logic [AW-1:0] rd_adr,
                           input bit verbose);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_adr  = adr;
        bus.wr_data = dat;
        rd({tag, "_pre"}, rd_adr);
        @(posedge clk);
        if (reset && adr != '0) model[adr] = dat;
        #1;
        bus.wr_en = 1'b0;
        rd({tag, "_post"}, rd_adr);
        if (verbose)
            $display("txn %-10s wr[%03h]<=%03h rd %03h -> %03h", tag, adr, dat, rd_adr, bus.data_out);
    endtask

    initial begin
        logic [AW-1:0] a, d, r;

        bus.data_in = '0;
        bus.wr_en   = 1'b0;
        bus.wr_adr  = '0;
        bus.wr_data = '0;
        model_reset();

        #2 reset = 1'b0;
        #10;
        rd("rst_iadd", 9'h060);
        rd("rst_zero", 9'h000);
        @(negedge clk);
        reset = 1'b1;

        rd("def_60",  9'h060);
        rd("def_100", 9'h100);
        rd("def_101", 9'h101);
        rd("def_05",  9'h005);

        wr_edge("wr05",    9'h005, 9'h120, 9'h005, 1'b1);
        wr_edge("wr_nop",  9'h000, 9'h1FF, 9'h000, 1'b1);
        wr_edge("wr120",   9'h120, 9'h121, 9'h120, 1'b1);
        wr_edge("self",    9'h130, 9'h130, 9'h130, 1'b1);

        // Asynchronous reset mid-cycle, no clock edge in between.
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        rd("arst_120", 9'h120);
        rd("arst_05",  9'h005);
        wr_edge("wr_in_rst", 9'h005, 9'h077, 9'h005, 1'b1);

        @(negedge clk);
        reset = 1'b1;
        rd("rel_60", 9'h060);
        wr_edge("first_wr", 9'h010, 9'h110, 9'h010, 1'b1);
        wr_edge("chain2",   9'h110, 9'h111, 9'h110, 1'b1);

        a = 9'h010;
        for (int s = 0; s < 3; s++) begin
            rd($sformatf("walk%0d", s), a);
            $display("txn walk%0d     %03h -> %03h", s, a, bus.data_out);
            a = model[a];
        end
        check_val("walk_end", a, 9'h000);

        for (int k = 0; k < 1000; k++) begin
            a = AW'($urandom_range(0, ND - 1));
            d = AW'($urandom_range(0, ND - 1));
            r = ($urandom_range(0, 1) == 1) ? a : AW'($urandom_range(0, ND - 1));
            wr_edge($sformatf("rnd%0d", k), a, d, r, 1'b0);
        end
        $display("txn rnd sweep 1000 writes done");

        repeat (20) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < ND; i += 37) rd($sformatf("hold%03h", i), AW'(i));
        rd("hold_nop", 9'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/next_adr_rom.md
NEXT_ADR_ROM -- requirements
Module: next_adr_rom

Interface
REQ-001 The parameter list SHALL be: ADR_W, default `adr_rom_adr_size (9), microcode address width.
REQ-002 The parameter list SHALL also be: DEPTH, default 2**ADR_W, number of table entries.
REQ-003 The clock port SHALL be: clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-004 The reset port SHALL be: reset  input  1  asynchronous, active-low reset.
REQ-005 The port data_in SHALL be: data_in  input  ADR_W  current microcode address (state_machine com_adr).
REQ-006 The port data_out SHALL be: data_out  output  ADR_W  successor microcode address; 0 = end of sequence.
REQ-007 The port wr_en SHALL be: wr_en  input  1  table write strobe, active-high.
REQ-008 The port wr_adr SHALL be: wr_adr  input  ADR_W  table entry to write.
REQ-009 The port wr_data SHALL be: wr_data  input  ADR_W  successor value to store.

Function
REQ-010 The block SHALL hold DEPTH entries of ADR_W bits, indexed by address.
REQ-011 data_out SHALL equal table[data_in] combinationally, with zero-cycle latency and no register on the read path, so that state_machine can use it in the same cycle.
REQ-012 Addresses 0..255 SHALL be opcode entry points; addresses 256..DEPTH-1 SHALL be continuation micro-steps.
REQ-013 When wr_en=1 at a rising clk edge with reset high, table[wr_adr] SHALL take the value wr_data.
REQ-014 A write to wr_adr=0 SHALL be ignored, so entry 0 (nop) always reads 0.
REQ-015 When wr_adr equals data_in, data_out SHALL show the old value before the write edge and wr_data after it; there is no write-through bypass.
REQ-016 wr_data equal to wr_adr (a self-loop) SHALL be stored without any check.
REQ-017 While wr_en=0 the table SHALL hold its contents indefinitely.
REQ-018 data_in SHALL never be out of range, because DEPTH = 2**ADR_W; if DEPTH < 2**ADR_W, a read of an address >= DEPTH SHALL return 0 and a write to such an address SHALL be ignored.

Reset
REQ-019 While reset=0, every entry SHALL immediately (asynchronously) take its default value from DEFAULT_NEXT_ADR, and data_out SHALL follow from the table.
REQ-020 While reset=0, writes SHALL be blocked.
REQ-021 Reset asserted in the same cycle as a write SHALL win; the entry SHALL end at its default value.
REQ-022 After reset is released, the first write SHALL take effect at the next rising clk edge.

Structure
REQ-023 The shared package/header me_consts.vh SHALL hold adr_rom_adr_size, the opcode range boundary (256) and DEFAULT_NEXT_ADR, a function returning the default entry for an index.
REQ-024 The shipped DEFAULT_NEXT_ADR image SHALL be: every entry 0, except entry 0x60 (iadd) -> 0x100, entry 0x100 -> 0x101, and entry 0x101 -> 0.
REQ-025 The block SHALL be a single flat module with no sub-modules, implemented as a register array with a combinational read mux.

Verification
REQ-026 Scenario: pulse reset low, then release; data_in=0x60 -> data_out=0x100; data_in=0x100 -> 0x101; data_in=0x101 -> 0; data_in=0x05 -> 0.
REQ-027 Scenario: wr_en=1, wr_adr=0x05, wr_data=0x120 for one edge; data_in=0x05 -> data_out=0x000 before the edge and 0x120 after it, with no added cycle.
REQ-028 Scenario: wr_en=1, wr_adr=0, wr_data=0x1FF -> data_in=0 still gives data_out=0.
REQ-029 Scenario: write 0x120 -> 0x121, then assert reset=0 mid-cycle with no clock edge -> data_in=0x120 gives data_out=0 immediately; a write presented during reset has no effect.
REQ-030 Scenario: chain walk: write 0x10 -> 0x110 and 0x110 -> 0x111, then step data_in through each returned value -> sequence 0x110, 0x111, 0, terminating the state_machine ITERATE loop.
REQ-031 Scenario: a random sweep of 1000 writes compared against a reference model, with simultaneous write and read to the same address -> old value before the edge, new value after it.
